// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port RAM arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 3;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_MEM
    } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of MEM grants that IF has had to sit through.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_C)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sat = (count_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between IF and MEM, MEM first,
// with a starvation guard for IF and branch-flush cancellation of fetches.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cancel_q, cancel_d;
    logic             store_q, store_d;

    logic done, arb_ok, grant_if, grant_mem, starve_sat;

    // Gating with reset keeps every output at 0 the moment reset rises.
    always_comb begin
        done      = !reset && (state_q == BUSY) && (cnt_q == '0);
        arb_ok    = !reset && ((state_q == IDLE) || done);
        grant_if  = arb_ok && if_req && (starve_sat || !mem_req);
        grant_mem = arb_ok && mem_req && !grant_if;
    end

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_mem && if_req),
        .clr   (grant_if || !if_req),
        .sat   (starve_sat)
    );

    always_comb begin
        if_gnt     = grant_if;
        mem_gnt    = grant_mem;
        ram_en     = grant_if || grant_mem;
        ram_we     = grant_mem && mem_we;
        ram_addr   = grant_mem ? mem_addr : (grant_if ? if_addr : '0);
        ram_wdata  = (grant_mem && mem_we) ? mem_wdata : '0;
        if_rvalid  = done && (owner_q == OWN_IF) && !cancel_q && !if_flush;
        mem_rvalid = done && (owner_q == OWN_MEM);
        if_rdata   = if_rvalid ? ram_rdata : '0;
        mem_rdata  = (mem_rvalid && !store_q) ? ram_rdata : '0;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        cancel_d = cancel_q;
        store_d  = store_q;
        if (state_q == BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if ((owner_q == OWN_IF) && if_flush) begin
                cancel_d = 1'b1;
            end
        end
        // A back-to-back grant at completion overrides the return to IDLE.
        if (grant_if || grant_mem) begin
            state_d  = BUSY;
            owner_d  = grant_if ? OWN_IF : OWN_MEM;
            cnt_d    = LAT_INIT;
            cancel_d = grant_if && if_flush;
            store_d  = grant_mem && mem_we;
        end else if (done) begin
            state_d  = IDLE;
            owner_d  = OWN_NONE;
            cancel_d = 1'b0;
            store_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
            store_q  <= store_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency RAM model.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req, if_flush, mem_req, mem_we;
    logic [ADDR_W-1:0] if_addr, mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              if_gnt, if_rvalid, mem_gnt, mem_rvalid;
    logic [DATA_W-1:0] if_rdata, mem_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM: word at byte address A preloads to 0xC0DE0000 | A; read-before-write.
    logic [DATA_W-1:0] ram [0:1023];
    logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hC0DE_0000 | (i << 2);
        end else if (ram_en && ram_we) begin
            ram[ram_addr[11:2]] <= ram_wdata;
        end
        rd_pipe[0] <= ram_en ? ram[ram_addr[11:2]] : 32'h5A5A_5A5A;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign ram_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_b({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk_b({tag, "_mem_gnt"}, mem_gnt, 1'b0);
        chk_b({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        chk_b({tag, "_mem_rvalid"}, mem_rvalid, 1'b0);
        chk_b({tag, "_ram_en"}, ram_en, 1'b0);
        chk_b({tag, "_ram_we"}, ram_we, 1'b0);
        chk_w({tag, "_ram_addr"}, ram_addr, 32'h0);
        chk_w({tag, "_ram_wdata"}, ram_wdata, 32'h0);
        chk_w({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk_w({tag, "_mem_rdata"}, mem_rdata, 32'h0);
    endtask

    initial begin
        drive_idle();
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // IF only, address 0x40 held
        @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
        chk_b("if1_gnt", if_gnt, 1'b1);
        chk_b("if1_ram_en", ram_en, 1'b1);
        chk_b("if1_ram_we", ram_we, 1'b0);
        chk_w("if1_ram_addr", ram_addr, 32'h40);
        @(negedge clk); #1;
        chk_b("if1_busy_gnt", if_gnt, 1'b0);
        chk_b("if1_busy_rvalid", if_rvalid, 1'b0);
        @(negedge clk); #1;
        chk_b("if1_rvalid", if_rvalid, 1'b1);
        chk_w("if1_rdata", if_rdata, 32'hC0DE_0040);
        chk_b("if1_regrant", if_gnt, 1'b1);
        @(negedge clk); if_req = 1'b0; #1;
        @(negedge clk); #1;
        chk_b("if2_rvalid", if_rvalid, 1'b1);
        chk_w("if2_rdata", if_rdata, 32'hC0DE_0040);
        chk_b("if2_no_gnt", if_gnt, 1'b0);

        // IF and MEM together: MEM first, IF at MEM completion
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h44;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; #1;
        chk_b("both_mem_gnt", mem_gnt, 1'b1);
        chk_b("both_if_gnt", if_gnt, 1'b0);
        chk_w("both_ram_addr", ram_addr, 32'h100);
        @(negedge clk); mem_req = 1'b0; #1;
        @(negedge clk); #1;
        chk_b("both_mem_rvalid", mem_rvalid, 1'b1);
        chk_w("both_mem_rdata", mem_rdata, 32'hC0DE_0100);
        chk_b("both_if_gnt_late", if_gnt, 1'b1);
        chk_w("both_if_ram_addr", ram_addr, 32'h44);
        @(negedge clk); if_req = 1'b0; #1;
        @(negedge clk); #1;
        chk_b("both_if_rvalid", if_rvalid, 1'b1);
        chk_b("both_no_mem_rvalid", mem_rvalid, 1'b0);
        chk_w("both_if_rdata", if_rdata, 32'hC0DE_0044);

        // Starvation: four MEM grants, then IF, then MEM again
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
                if_req = 1'b1; if_addr = 32'h48;
            end
            #1;
            chk_b($sformatf("starve_if_gnt_%0d", k), if_gnt, k == 4);
            chk_b($sformatf("starve_mem_gnt_%0d", k), mem_gnt, k != 4);
            chk_b($sformatf("starve_mem_rvalid_%0d", k), mem_rvalid, (k >= 1) && (k <= 4));
            chk_b($sformatf("starve_if_rvalid_%0d", k), if_rvalid, k == 5);
            if (k == 5) chk_w("starve_if_rdata", if_rdata, 32'hC0DE_0048);
            @(negedge clk);
            if (k == 5) begin
                mem_req = 1'b0; if_req = 1'b0;
            end
            #1;
            chk_b($sformatf("starve_busy_%0d", k), if_gnt | mem_gnt, 1'b0);
        end
        @(negedge clk); #1;
        chk_b("starve_last_rvalid", mem_rvalid, 1'b1);
        chk_w("starve_last_rdata", mem_rdata, 32'hC0DE_0100);

        // Store then load of the same address
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; #1;
        chk_b("st_gnt", mem_gnt, 1'b1);
        chk_b("st_ram_we", ram_we, 1'b1);
        chk_w("st_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk_w("st_ram_addr", ram_addr, 32'h200);
        @(negedge clk); mem_req = 1'b0; #1;
        @(negedge clk); mem_req = 1'b1; mem_we = 1'b0; mem_wdata = '0; #1;
        chk_b("st_rvalid", mem_rvalid, 1'b1);
        chk_w("st_rdata_zero", mem_rdata, 32'h0);
        chk_b("ld_gnt", mem_gnt, 1'b1);
        chk_b("ld_ram_we", ram_we, 1'b0);
        @(negedge clk); mem_req = 1'b0; #1;
        @(negedge clk); #1;
        chk_b("ld_rvalid", mem_rvalid, 1'b1);
        chk_w("ld_rdata", mem_rdata, 32'hDEAD_BEEF);

        // Flush one cycle after grant, next fetch granted at completion
        @(negedge clk); if_req = 1'b1; if_addr = 32'h4C; #1;
        chk_b("fl_gnt", if_gnt, 1'b1);
        @(negedge clk); if_flush = 1'b1; if_addr = 32'h50; #1;
        @(negedge clk); if_flush = 1'b0; #1;
        chk_b("fl_no_rvalid", if_rvalid, 1'b0);
        chk_b("fl_next_gnt", if_gnt, 1'b1);
        chk_w("fl_next_addr", ram_addr, 32'h50);
        @(negedge clk); if_req = 1'b0; #1;
        @(negedge clk); #1;
        chk_b("fl_next_rvalid", if_rvalid, 1'b1);
        chk_w("fl_next_rdata", if_rdata, 32'hC0DE_0050);

        // Flush in the same cycle as the grant
        @(negedge clk); if_req = 1'b1; if_addr = 32'h54; if_flush = 1'b1; #1;
        chk_b("flg_gnt", if_gnt, 1'b1);
        @(negedge clk); if_req = 1'b0; if_flush = 1'b0; #1;
        @(negedge clk); #1;
        chk_b("flg_no_rvalid", if_rvalid, 1'b0);

        // Reset while BUSY
        @(negedge clk); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; #1;
        chk_b("rb_mem_gnt", mem_gnt, 1'b1);
        @(negedge clk); mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h58; #1;
        chk_b("rb_busy_if_gnt", if_gnt, 1'b0);
        #1; reset = 1'b1; #1;
        chk_all_zero("rb_async");
        @(negedge clk); #1;
        chk_b("rb_no_mem_rvalid", mem_rvalid, 1'b0);
        chk_b("rb_held_if_gnt", if_gnt, 1'b0);
        @(negedge clk); reset = 1'b0; #1;
        chk_b("rb_first_if_gnt", if_gnt, 1'b1);
        chk_w("rb_first_addr", ram_addr, 32'h58);
        @(negedge clk); if_req = 1'b0; #1;
        @(negedge clk); #1;
        chk_b("rb_if_rvalid", if_rvalid, 1'b1);
        chk_w("rb_if_rdata", if_rdata, 32'hC0DE_0058);
        chk_b("rb_mem_rvalid_quiet", mem_rvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
